// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, threshold flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have 1-cycle latency.
module sync_fifo_flags #(
  parameter int width     = 16,
  parameter int depth     = 8,
  parameter int af_thresh = depth - 2,
  parameter int ae_thresh = 1,
  localparam int adr_width = $clog2(depth),
  localparam int cnt_width = $clog2(depth + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [width-1:0]     data_in,
  input  logic                 we,
  input  logic                 re,
  output logic [width-1:0]     data_out,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [cnt_width-1:0] count,
  output logic                 overflow,
  output logic                 underflow
);

  logic [width-1:0]     r_mem [depth];
  logic [adr_width-1:0] r_wr_ptr;
  logic [adr_width-1:0] r_rd_ptr;
  logic [cnt_width-1:0] r_count;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_ok;
  logic                 w_rd_ok;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [adr_width-1:0] ptr_next(input logic [adr_width-1:0] ptr);
    return (ptr == adr_width'(depth - 1)) ? '0 : ptr + adr_width'(1);
  endfunction

  assign w_full  = (r_count == cnt_width'(depth));
  assign w_empty = (r_count == '0);
  assign w_rd_ok = re && !w_empty && !rst;
  assign w_wr_ok = we && (!w_full || w_rd_ok) && !rst;

  // Stage: pointer, count and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_rd_ok) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + cnt_width'(1);
        2'b01:   r_count <= r_count - cnt_width'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= we && !w_wr_ok;
      r_underflow <= re && w_empty;
    end
  end

  // Stage: storage array, never cleared
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is visible whenever occupied; re only pops.
  assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
`else
  logic [width-1:0] r_data_out;

  // Stage: registered read port, holds when no read is accepted
  always_ff @(posedge clk) begin
    if (rst)          r_data_out <= '0;
    else if (w_rd_ok) r_data_out <= r_mem[r_rd_ptr];
  end

  assign data_out = r_data_out;
`endif

  assign fifo_full    = w_full;
  assign fifo_empty   = w_empty;
  assign almost_full  = (int'(r_count) >= af_thresh);
  assign almost_empty = (int'(r_count) <= ae_thresh);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags: depth-8 and depth-5 instances.
// Honours SYNC_FIFO_FWFT_EN to select the read-mode scenario.
module tb_sync_fifo_flags;

  logic        clk;
  logic        rst;

  logic [15:0] a_din, a_dout;
  logic        a_we, a_re, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0]  a_cnt;

  logic [15:0] b_din, b_dout;
  logic        b_we, b_re, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0]  b_cnt;

  int n_cmp;
  int n_err;

  int          bq[$];
  int          bk;
  logic [15:0] b_exp_dout;

  sync_fifo_flags #(.width(16), .depth(8)) u_a (
    .clk(clk), .rst(rst), .data_in(a_din), .we(a_we), .re(a_re),
    .data_out(a_dout), .fifo_full(a_full), .fifo_empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
    .overflow(a_ovf), .underflow(a_unf)
  );

  sync_fifo_flags #(.width(16), .depth(5)) u_b (
    .clk(clk), .rst(rst), .data_in(b_din), .we(b_we), .re(b_re),
    .data_out(b_dout), .fifo_full(b_full), .fifo_empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
    .overflow(b_ovf), .underflow(b_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_state(input string tag, input int cnt, input logic [15:0] dout);
    chk({tag, "_cnt"},   32'(a_cnt),   32'(cnt));
    chk({tag, "_full"},  32'(a_full),  32'(cnt == 8));
    chk({tag, "_empty"}, 32'(a_empty), 32'(cnt == 0));
    chk({tag, "_af"},    32'(a_af),    32'(cnt >= 6));
    chk({tag, "_ae"},    32'(a_ae),    32'(cnt <= 1));
    chk({tag, "_dout"},  32'(a_dout),  32'(dout));
  endtask

  task automatic b_op(input bit w, input bit r);
    bit full_e, empty_e, wok, rok;
    full_e  = (bq.size() == 5);
    empty_e = (bq.size() == 0);
    rok     = r && !empty_e;
    wok     = w && (!full_e || rok);
    b_we    = w;
    b_re    = r;
    b_din   = 16'(32'h100 + bk);
    tick;
    b_we = 1'b0;
    b_re = 1'b0;
    if (rok) b_exp_dout = 16'(bq.pop_front());
    if (wok) bq.push_back(32'h100 + bk);
    if (w) bk++;
    chk("b_cnt",  32'(b_cnt),  32'(bq.size()));
    chk("b_full", 32'(b_full), 32'(bq.size() == 5));
    chk("b_dout", 32'(b_dout), 32'(b_exp_dout));
    chk("b_ovf",  32'(b_ovf),  32'(w && !wok));
    chk("b_unf",  32'(b_unf),  32'(r && empty_e));
    chk("b_max",  32'(b_cnt <= 3'd5), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bk = 0;
    b_exp_dout = '0;
    rst = 1'b1;
    a_din = '0; a_we = 1'b0; a_re = 1'b0;
    b_din = '0; b_we = 1'b0; b_re = 1'b0;
    tick;
    tick;
    a_state("rst", 0, 16'h0000);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_unf", 32'(a_unf), 32'd0);
    chk("rst_b_empty", 32'(b_empty), 32'd1);
    rst = 1'b0;

`ifdef SYNC_FIFO_FWFT_EN
    a_we = 1'b1; a_din = 16'h1234;
    tick;
    a_we = 1'b0;
    a_state("fw_w1", 1, 16'h1234);
    a_we = 1'b1; a_din = 16'h5678;
    tick;
    a_we = 1'b0;
    a_state("fw_w2", 2, 16'h1234);
    a_re = 1'b1;
    tick;
    a_state("fw_pop1", 1, 16'h5678);
    tick;
    a_state("fw_pop2", 0, 16'h0000);
    tick;
    a_re = 1'b0;
    chk("fw_unf", 32'(a_unf), 32'd1);
    a_state("fw_extra", 0, 16'h0000);
    tick;
    chk("fw_unf_clr", 32'(a_unf), 32'd0);
`else
    // Fill 0x0001..0x0008, then overflow
    for (int i = 1; i <= 8; i++) begin
      a_we = 1'b1; a_din = 16'(i);
      tick;
      a_state("fill", i, 16'h0000);
    end
    a_din = 16'hDEAD;
    tick;
    a_we = 1'b0;
    chk("ovf_pulse", 32'(a_ovf), 32'd1);
    a_state("ovf", 8, 16'h0000);
    tick;
    chk("ovf_clr", 32'(a_ovf), 32'd0);
    chk("ovf_cnt", 32'(a_cnt), 32'd8);

    // Drain in order, then underflow
    for (int i = 1; i <= 8; i++) begin
      a_re = 1'b1;
      tick;
      a_state("drain", 8 - i, 16'(i));
    end
    tick;
    a_re = 1'b0;
    chk("unf_pulse", 32'(a_unf), 32'd1);
    a_state("unf", 0, 16'h0008);
    tick;
    chk("unf_clr", 32'(a_unf), 32'd0);
    chk("unf_dout", 32'(a_dout), 32'h0008);

    // Full with simultaneous write and read
    for (int i = 1; i <= 8; i++) begin
      a_we = 1'b1; a_din = 16'(i);
      tick;
    end
    a_re = 1'b1; a_din = 16'h00AA;
    tick;
    a_we = 1'b0;
    chk("fwr_ovf", 32'(a_ovf), 32'd0);
    a_state("fwr", 8, 16'h0001);
    for (int i = 2; i <= 9; i++) begin
      tick;
      a_state("fwr_drain", 9 - i, (i == 9) ? 16'h00AA : 16'(i));
    end

    // Empty with simultaneous write and read
    a_we = 1'b1; a_re = 1'b1; a_din = 16'h0055;
    tick;
    a_we = 1'b0;
    chk("ewr_unf", 32'(a_unf), 32'd1);
    a_state("ewr", 1, 16'h00AA);
    tick;
    a_re = 1'b0;
    a_state("ewr_rd", 0, 16'h0055);

    // Reset mid-operation with a write pending
    for (int i = 1; i <= 5; i++) begin
      a_we = 1'b1; a_din = 16'(32'h10 + i);
      tick;
    end
    chk("pre_rst_cnt", 32'(a_cnt), 32'd5);
    rst = 1'b1; a_din = 16'h0077;
    tick;
    rst = 1'b0; a_we = 1'b0;
    a_state("mid_rst", 0, 16'h0000);
    a_re = 1'b1;
    tick;
    a_re = 1'b0;
    chk("mid_rst_unf", 32'(a_unf), 32'd1);
    a_state("mid_rst_rd", 0, 16'h0000);

    // depth=5: W,W,R repeated for 12 writes
    for (int g = 0; g < 6; g++) begin
      b_op(1'b1, 1'b0);
      b_op(1'b1, 1'b0);
      b_op(1'b0, 1'b1);
    end
    while (bq.size() > 0) b_op(1'b0, 1'b1);
    chk("b_end_empty", 32'(b_empty), 32'd1);
    chk("b_end_dout", 32'(b_dout), 32'h010A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
